// File: rtl/cordic_vec_post.sv
// Post-processing for the vector-mode CORDIC array: gain-compensated
// magnitude via a serial shift-add multiply, and full-circle phase.
module cordic_vec_post #(
  parameter int XY_BITS    = 16,
  parameter int THETA_BITS = 16,
  parameter int GAIN_INV   = 19896,
  parameter int MUL_ITER   = 15,
  parameter int PHASE_90   = 23040,
  parameter int PHASE_180  = 46080
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [XY_BITS:0] x_in,
  input  logic signed [THETA_BITS:0] theta_in,
  input  logic [1:0]              quad_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [XY_BITS:0] mag_o,
  output logic signed [THETA_BITS:0] phase_o
);

  localparam int PW   = THETA_BITS + 2;
  localparam int FRAC = 15;

  localparam logic [15:0] LP_GAIN = 16'(GAIN_INV);
  localparam logic [3:0]  LP_LAST = 4'(MUL_ITER - 1);
  localparam logic signed [PW-1:0] LP_P90  = PW'(PHASE_90);
  localparam logic signed [PW-1:0] LP_P180 = PW'(PHASE_180);
  localparam logic signed [PW-1:0] LP_P360 = PW'(2 * PHASE_180);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [XY_BITS-1:0]       r_a;
  logic [32:0]              r_acc;
  logic [3:0]               r_cnt;
  logic signed [THETA_BITS:0] r_ph_cap;
  logic [XY_BITS:0]         r_mag;
  logic signed [THETA_BITS:0] r_phase;

  logic                     w_last;
  logic                     w_take;
  logic [XY_BITS-1:0]       w_a;
  logic [32:0]              w_add;
  logic [32:0]              w_acc_nx;
  logic [32:0]              w_rnd;
  logic [XY_BITS:0]         w_mag;
  logic signed [PW-1:0]     w_th;
  logic signed [PW-1:0]     w_off;
  logic signed [PW-1:0]     w_sum;
  logic signed [PW-1:0]     w_wrap;
  logic signed [THETA_BITS:0] w_ph;

  assign w_last = (r_cnt == LP_LAST);
  assign w_take = (r_state == S_IDLE) && in_valid;

  // Negative x is a degenerate array output; clamp it to zero.
  assign w_a      = x_in[XY_BITS] ? '0 : x_in[XY_BITS-1:0];
  assign w_add    = LP_GAIN[r_cnt] ? (33'(r_a) << r_cnt) : '0;
  assign w_acc_nx = r_acc + w_add;
  assign w_rnd    = w_acc_nx + (33'(1) << (FRAC - 1));
  assign w_mag    = (XY_BITS + 1)'(w_rnd >> FRAC);

  assign w_th  = {theta_in[THETA_BITS], theta_in};
  assign w_sum = w_th + w_off;
  assign w_ph  = (THETA_BITS + 1)'(w_wrap);

  always_comb begin
    w_off = '0;
    unique case (quad_in)
      2'd0: w_off = '0;
      2'd1: w_off = LP_P90;
      2'd2: w_off = -LP_P90;
      2'd3: w_off = LP_P180;
    endcase
  end

  // Fold into (-180, +180]; -180 itself maps to +180.
  always_comb begin
    w_wrap = w_sum;
    if (w_sum > LP_P180)
      w_wrap = w_sum - LP_P360;
    else if (w_sum <= -LP_P180)
      w_wrap = w_sum + LP_P360;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid)  w_state_nx = S_MUL;
      S_MUL:  if (w_last)    w_state_nx = S_DONE;
      S_DONE: if (out_ready) w_state_nx = S_IDLE;
      default:               w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ph_cap <= '0;
      r_mag    <= '0;
      r_phase  <= '0;
    end else if (w_take) begin
      r_a      <= w_a;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ph_cap <= w_ph;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_nx;
      if (w_last) begin
        r_mag   <= w_mag;
        r_phase <= r_ph_cap;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign mag_o   = r_mag;
  assign phase_o = r_phase;

endmodule
